// File: rtl/cpu6502_pkg.sv
// Shared 6502 core definitions: fetch FSM states, reset PC and the opcode length rule
// used by both the fetch stage and the addressing-mode calculator.
package cpu6502_pkg;

    typedef enum logic [2:0] {
        S_ISSUE_OP = 3'd0,
        S_CAP_OP   = 3'd1,
        S_CAP_B1   = 3'd2,
        S_CAP_B2   = 3'd3,
        S_HOLD     = 3'd4
    } fetch_state_t;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0200;

    // Instruction length in bytes from the opcode; illegal column-3/7/B/F opcodes count as one byte.
    function automatic logic [1:0] opcode_length(input logic [7:0] opcode);
        logic [1:0] len_s;
        len_s = 2'd1;
        case (opcode[3:0])
            4'h0: begin
                if (opcode == 8'h20) begin
                    len_s = 2'd3;
                end else if ((opcode == 8'h00) || (opcode == 8'h40) || (opcode == 8'h60)) begin
                    len_s = 2'd1;
                end else begin
                    len_s = 2'd2;
                end
            end
            4'h1, 4'h2, 4'h4, 4'h5, 4'h6: len_s = 2'd2;
            4'h8, 4'hA:                   len_s = 2'd1;
            4'h9: begin
                if (opcode[4] == 1'b1) begin
                    len_s = 2'd3;
                end else begin
                    len_s = 2'd2;
                end
            end
            4'hC, 4'hD, 4'hE:             len_s = 2'd3;
            default:                      len_s = 2'd1;
        endcase
        return len_s;
    endfunction

endpackage

// File: rtl/opcode_length_lut.sv
// Combinational opcode -> instruction length lookup for the fetch stage.
module opcode_length_lut
    import cpu6502_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] length
);

    assign length = opcode_length(opcode);

endmodule

// File: rtl/instruction_fetch.sv
// 6502 fetch stage: reads opcode/operand bytes and hands out one instruction bundle per handshake.
// Optional IFETCH_FAST_EN overlaps the next opcode read with the accepting cycle.
module instruction_fetch
    import cpu6502_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [7:0]  inst_opcode,
    output logic [7:0]  inst_operand1,
    output logic [7:0]  inst_operand2,
    output logic [15:0] inst_pc,
    output logic [1:0]  inst_length,
    output logic [2:0]  debug_state
);

    fetch_state_t state_r;
    logic [15:0]  pc_r;
    logic [15:0]  inst_pc_r;
    logic [1:0]   len_r;
    logic [7:0]   opcode_r;
    logic [7:0]   operand1_r;
    logic [7:0]   operand2_r;
    logic         valid_r;
    logic [1:0]   lut_len_s;
    logic [15:0]  next_pc_s;

    opcode_length_lut u_length_lut (
        .opcode (mem_rdata),
        .length (lut_len_s)
    );

    assign next_pc_s = pc_r + {14'd0, len_r};

    // Read strobe/address follow the state; in S_CAP_OP the byte just returned decides on operand 1.
    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = pc_r;
        if (!rst_n) begin
            mem_rd   = 1'b0;
            mem_addr = pc_r;
        end else begin
            case (state_r)
                S_ISSUE_OP: begin
                    mem_rd   = 1'b1;
                    mem_addr = pc_r;
                end
                S_CAP_OP: begin
                    mem_rd   = (lut_len_s > 2'd1);
                    mem_addr = pc_r + 16'd1;
                end
                S_CAP_B1: begin
                    mem_rd   = (len_r == 2'd3);
                    mem_addr = pc_r + 16'd2;
                end
                S_HOLD: begin
`ifdef IFETCH_FAST_EN
                    mem_rd   = inst_ready & ~redirect;
                    mem_addr = next_pc_s;
`else
                    mem_rd   = 1'b0;
                    mem_addr = pc_r;
`endif
                end
                default: begin
                    mem_rd   = 1'b0;
                    mem_addr = pc_r;
                end
            endcase
        end
    end

    // Fetch FSM and bundle registers; a redirect overrides everything, including a completing handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_ISSUE_OP;
            pc_r       <= RESET_PC;
            inst_pc_r  <= 16'h0000;
            len_r      <= 2'd0;
            opcode_r   <= 8'h00;
            operand1_r <= 8'h00;
            operand2_r <= 8'h00;
            valid_r    <= 1'b0;
        end else if (redirect) begin
            state_r    <= S_ISSUE_OP;
            pc_r       <= redirect_pc;
            inst_pc_r  <= 16'h0000;
            len_r      <= 2'd0;
            opcode_r   <= 8'h00;
            operand1_r <= 8'h00;
            operand2_r <= 8'h00;
            valid_r    <= 1'b0;
        end else begin
            case (state_r)
                S_ISSUE_OP: begin
                    state_r <= S_CAP_OP;
                end
                S_CAP_OP: begin
                    opcode_r   <= mem_rdata;
                    len_r      <= lut_len_s;
                    operand1_r <= 8'h00;
                    operand2_r <= 8'h00;
                    inst_pc_r  <= pc_r;
                    if (lut_len_s > 2'd1) begin
                        state_r <= S_CAP_B1;
                    end else begin
                        state_r <= S_HOLD;
                        valid_r <= 1'b1;
                    end
                end
                S_CAP_B1: begin
                    operand1_r <= mem_rdata;
                    if (len_r == 2'd3) begin
                        state_r <= S_CAP_B2;
                    end else begin
                        state_r <= S_HOLD;
                        valid_r <= 1'b1;
                    end
                end
                S_CAP_B2: begin
                    operand2_r <= mem_rdata;
                    state_r    <= S_HOLD;
                    valid_r    <= 1'b1;
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        pc_r    <= next_pc_s;
                        valid_r <= 1'b0;
`ifdef IFETCH_FAST_EN
                        state_r <= S_CAP_OP;
`else
                        state_r <= S_ISSUE_OP;
`endif
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                default: begin
                    state_r <= S_ISSUE_OP;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign inst_valid    = valid_r;
    assign inst_opcode   = opcode_r;
    assign inst_operand1 = operand1_r;
    assign inst_operand2 = operand2_r;
    assign inst_pc       = inst_pc_r;
    assign inst_length   = len_r;
    assign debug_state   = state_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed program, table-driven opcode vectors,
// multi-cycle corner sequences and a randomized run against a byte-level fetch model.
module tb_instruction_fetch;
    import cpu6502_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [7:0]  inst_opcode, inst_operand1, inst_operand2;
    logic [15:0] inst_pc;
    logic [1:0]  inst_length;
    logic [2:0]  debug_state;

    logic [15:0] w_mem_addr;
    logic        w_mem_rd;
    logic [7:0]  w_mem_rdata;
    logic        w_redirect = 1'b0;
    logic [15:0] w_redirect_pc = 16'h0000;
    logic        w_valid;
    logic        w_ready = 1'b1;
    logic [7:0]  w_opcode, w_operand1, w_operand2;
    logic [15:0] w_pc;
    logic [1:0]  w_length;
    logic [2:0]  w_state;

    logic [7:0]  mem [0:65535];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        rnd_on = 1'b0;
    int          hs_count = 0;
    logic [63:0] wq [$];

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_opcode(inst_opcode), .inst_operand1(inst_operand1), .inst_operand2(inst_operand2),
        .inst_pc(inst_pc), .inst_length(inst_length), .debug_state(debug_state)
    );

    instruction_fetch #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .mem_addr(w_mem_addr), .mem_rd(w_mem_rd), .mem_rdata(w_mem_rdata),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc), .inst_valid(w_valid), .inst_ready(w_ready),
        .inst_opcode(w_opcode), .inst_operand1(w_operand1), .inst_operand2(w_operand2),
        .inst_pc(w_pc), .inst_length(w_length), .debug_state(w_state)
    );

    always #5 clk = ~clk;

    // Synchronous byte memories; idle cycles return junk so stale data cannot be relied on.
    always @(posedge clk) begin
        mem_rdata <= mem_rd ? mem[mem_addr] : 8'($urandom);
        if (w_mem_addr == 16'hFFFE)      w_mem_rdata <= 8'h4C;
        else if (w_mem_addr == 16'hFFFF) w_mem_rdata <= 8'h00;
        else if (w_mem_addr == 16'h0000) w_mem_rdata <= 8'h30;
        else                             w_mem_rdata <= 8'hEA;
    end

    function automatic logic [63:0] mk(input logic [7:0] op, input logic [7:0] o1,
                                       input logic [7:0] o2, input logic [15:0] pc, input logic [1:0] len);
        return {22'd0, op, o1, o2, pc, len};
    endfunction

    function automatic logic [63:0] live_bundle();
        return mk(inst_opcode, inst_operand1, inst_operand2, inst_pc, inst_length);
    endfunction

    function automatic logic [1:0] ref_len(input logic [7:0] op);
        int lo, hi;
        lo = int'(op) % 16;
        hi = int'(op) / 16;
        if (lo == 0) begin
            if (op == 8'h20) return 2'd3;
            if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 2'd1;
            return 2'd2;
        end
        if (lo == 9) return (hi % 2 == 1) ? 2'd3 : 2'd2;
        if (lo >= 12 && lo <= 14) return 2'd3;
        if (lo == 1 || lo == 2 || lo == 4 || lo == 5 || lo == 6) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic [63:0] exp_bundle(input logic [15:0] pc);
        logic [1:0]  l;
        logic [15:0] p1, p2;
        logic [7:0]  b1, b2;
        l  = ref_len(mem[pc]);
        p1 = pc + 16'd1;
        p2 = pc + 16'd2;
        b1 = (l > 2'd1) ? mem[p1] : 8'h00;
        b2 = (l == 2'd3) ? mem[p2] : 8'h00;
        return mk(mem[pc], b1, b2, pc, l);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!inst_valid && n < 12) begin
            tick();
            n++;
        end
        if (!inst_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: inst_valid not seen within 12 cycles", name);
        end
    endtask

    task automatic wait_state(input string name, input logic [2:0] st);
        int n;
        n = 0;
        while (debug_state != st && n < 8) begin
            tick();
            n++;
        end
        check(name, 64'(debug_state), 64'(st));
    endtask

    // Reference monitor: every accepted bundle must be the instruction at the model PC.
    initial begin
        logic [15:0] m_pc;
        logic        hold_prev;
        logic [63:0] held;
        m_pc = 16'h0000;
        hold_prev = 1'b0;
        held = 64'd0;
        forever begin
            @(negedge clk);
            if (rst_n && w_valid && w_ready)
                wq.push_back(mk(w_opcode, w_operand1, w_operand2, w_pc, w_length));
            if (rnd_on && rst_n) begin
                if (hold_prev) begin
                    check("rnd_hold_valid", 64'(inst_valid), 64'd1);
                    check("rnd_hold_stable", live_bundle(), held);
                end
                if (inst_valid && inst_ready) begin
                    check("rnd_bundle", live_bundle(), exp_bundle(m_pc));
                    m_pc = m_pc + 16'(ref_len(mem[m_pc]));
                    hs_count++;
                end
                if (redirect) m_pc = redirect_pc;
                hold_prev = inst_valid && !inst_ready && !redirect;
                held = live_bundle();
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  b0, b1, b2;
        logic [7:0]  e_op, e_o1, e_o2;
        logic [1:0]  e_len;
    } vec_t;

    vec_t        vecs [14];
    logic [63:0] prog [3];

    initial begin
        int          n;
        logic [15:0] p;
        logic [7:0]  init_bytes [6];

        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        init_bytes = '{8'hA9, 8'h55, 8'hAD, 8'h34, 8'h12, 8'hEA};
        for (int i = 0; i < 6; i++) mem[16'h0200 + i] = init_bytes[i];
        prog[0] = mk(8'hA9, 8'h55, 8'h00, 16'h0200, 2'd2);
        prog[1] = mk(8'hAD, 8'h34, 8'h12, 16'h0202, 2'd3);
        prog[2] = mk(8'hEA, 8'h00, 8'h00, 16'h0205, 2'd1);

        vecs[0]  = '{16'h1000, 8'h20, 8'h34, 8'h12, 8'h20, 8'h34, 8'h12, 2'd3};
        vecs[1]  = '{16'h1010, 8'h00, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 2'd1};
        vecs[2]  = '{16'h1020, 8'h40, 8'hAA, 8'hBB, 8'h40, 8'h00, 8'h00, 2'd1};
        vecs[3]  = '{16'h1030, 8'h60, 8'hAA, 8'hBB, 8'h60, 8'h00, 8'h00, 2'd1};
        vecs[4]  = '{16'h1040, 8'hA0, 8'h05, 8'h77, 8'hA0, 8'h05, 8'h00, 2'd2};
        vecs[5]  = '{16'h1050, 8'hB9, 8'h00, 8'h20, 8'hB9, 8'h00, 8'h20, 2'd3};
        vecs[6]  = '{16'h1060, 8'h09, 8'h0F, 8'h99, 8'h09, 8'h0F, 8'h00, 2'd2};
        vecs[7]  = '{16'h1070, 8'h4C, 8'h00, 8'h80, 8'h4C, 8'h00, 8'h80, 2'd3};
        vecs[8]  = '{16'h1080, 8'h0A, 8'h11, 8'h22, 8'h0A, 8'h00, 8'h00, 2'd1};
        vecs[9]  = '{16'h1090, 8'h03, 8'h11, 8'h22, 8'h03, 8'h00, 8'h00, 2'd1};
        vecs[10] = '{16'h10A0, 8'hFF, 8'h11, 8'h22, 8'hFF, 8'h00, 8'h00, 2'd1};
        vecs[11] = '{16'h10B0, 8'hE6, 8'h44, 8'h55, 8'hE6, 8'h44, 8'h00, 2'd2};
        vecs[12] = '{16'h10C0, 8'h11, 8'h66, 8'h77, 8'h11, 8'h66, 8'h00, 2'd2};
        vecs[13] = '{16'hFFFF, 8'h8D, 8'h11, 8'h22, 8'h8D, 8'h11, 8'h22, 2'd3};

        // Reset state, then first read in the first cycle after release
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_bundle", live_bundle(), 64'd0);
        check("rst_state", 64'(debug_state), 64'(S_ISSUE_OP));
        check("rst_mem_rd", 64'(mem_rd), 64'd0);
        rst_n = 1'b1;
        #1;
        check("first_read", {47'd0, mem_rd, mem_addr}, {47'd0, 1'b1, 16'h0200});

        // First bundle, latency, then a 10-cycle stall
        wait_valid("first_bundle", n);
        check("lat_len2", 64'(n), 64'd3);
        check("prog0", live_bundle(), prog[0]);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", 64'(inst_valid), 64'd1);
            check("stall_bundle", live_bundle(), prog[0]);
            check("stall_no_rd", 64'(mem_rd), 64'd0);
        end
        inst_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            tick();
            wait_valid("prog_next", n);
            check("prog_bundle", live_bundle(), prog[k]);
        end

        // Throughput on a stream of single-byte NOPs
        for (int k = 0; k < 2; k++) begin
            tick();
            wait_valid("nop_stream", n);
`ifdef IFETCH_FAST_EN
            check("throughput", 64'(n + 1), 64'd2);
`else
            check("throughput", 64'(n + 1), 64'd3);
`endif
            check("nop_bundle", live_bundle(), mk(8'hEA, 8'h00, 8'h00, 16'h0206 + 16'(k), 2'd1));
        end
        inst_ready = 1'b0;

        // Table-driven opcode/length/latency vectors, each fetched via redirect
        for (int v = 0; v < 14; v++) begin
            p = vecs[v].addr;
            mem[p] = vecs[v].b0;
            p = p + 16'd1;
            mem[p] = vecs[v].b1;
            p = p + 16'd1;
            mem[p] = vecs[v].b2;
            redirect = 1'b1;
            redirect_pc = vecs[v].addr;
            tick();
            redirect = 1'b0;
            check("vec_cleared", 64'(inst_valid), 64'd0);
            wait_valid("vec_valid", n);
            check("vec_bundle", live_bundle(),
                  mk(vecs[v].e_op, vecs[v].e_o1, vecs[v].e_o2, vecs[v].addr, vecs[v].e_len));
            check("vec_latency", 64'(n + 1), 64'(vecs[v].e_len) + 64'd2);
        end

        // Redirect while capturing operand 1 of a 3-byte instruction
        mem[16'h3000] = 8'hEA;
        redirect = 1'b1;
        redirect_pc = 16'h0202;
        tick();
        redirect = 1'b0;
        wait_state("reach_cap_b1", S_CAP_B1);
        redirect = 1'b1;
        redirect_pc = 16'h3000;
        inst_ready = 1'b1;
        tick();
        redirect = 1'b0;
        wait_valid("redir_valid", n);
        check("redir_bundle", live_bundle(), mk(8'hEA, 8'h00, 8'h00, 16'h3000, 2'd1));
        inst_ready = 1'b0;

        // Reset asserted while capturing operand 2
        redirect = 1'b1;
        redirect_pc = 16'h0202;
        tick();
        redirect = 1'b0;
        wait_state("reach_cap_b2", S_CAP_B2);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(inst_valid), 64'd0);
        check("midrst_bundle", live_bundle(), 64'd0);
        check("midrst_state", 64'(debug_state), 64'(S_ISSUE_OP));
        check("midrst_mem_rd", 64'(mem_rd), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid("restart_valid", n);
        check("restart_bundle", live_bundle(), prog[0]);

        // Randomized run against the monitor's model
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rnd_on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            redirect = (i == 0) || ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFFD + 16'($urandom_range(0, 2));
            else redirect_pc = 16'($urandom);
            inst_ready = (i != 0) && ($urandom_range(0, 3) != 0);
            tick();
        end
        rnd_on = 1'b0;
        redirect = 1'b0;
        check("rnd_handshakes", 64'(hs_count > 300), 64'd1);

        // Wrap-around instance: operands straddle $FFFF -> $0000
        check("wrap_count", 64'(wq.size() >= 2), 64'd1);
        if (wq.size() >= 2) begin
            check("wrap_bundle", wq[0], mk(8'h4C, 8'h00, 8'h30, 16'hFFFE, 2'd3));
            check("wrap_next", wq[1], mk(8'hEA, 8'h00, 8'h00, 16'h0001, 2'd1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
